// File: rtl/frame_parser.sv
// Frame parser: hunts header / channel / payload / CRC / trailer frames on a 16-bit stream
// and drains CRC-clean frames into the downstream FIFO from ping-pong payload banks.
module frame_parser #(
    parameter logic [15:0] HEADER_WORD  = 16'hE0E0,
    parameter logic [15:0] TRAILER_WORD = 16'h0E0E,
    parameter int          MAX_WORDS    = 8,
    parameter logic [15:0] CRC_POLY     = 16'h1021,
    parameter logic [15:0] CRC_INIT     = 16'h0000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    output logic        crc_valid,
    output logic        crc_err,
    output logic        len_err,
    output logic        frame_drop
);
    typedef enum logic [1:0] {S_HUNT, S_HDR, S_CHAN, S_PAYLOAD} pstate_t;
    typedef enum logic [1:0] {D_IDLE, D_DESC, D_DATA} dstate_t;

    localparam int          AW   = $clog2(MAX_WORDS);
    localparam logic [3:0]  MAXC = 4'(MAX_WORDS);

    function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ CRC_POLY;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    pstate_t     r_state;
    dstate_t     r_dstate;
    logic [15:0] r_d1, r_d2, r_crc;
    logic [1:0]  r_fill;
    logic [3:0]  r_count, r_desc_len;
    logic [7:0]  r_ch, r_desc_ch;
    logic        r_wsel, r_rsel, r_start;
    logic        r_crc_valid, r_crc_err, r_len_err, r_frame_drop;
    logic [AW-1:0] r_ptr;
    logic [15:0] r_bank [0:2*MAX_WORDS-1];

    logic        w_full, w_trl, w_commit, w_overflow, w_chan_ok, w_drain_busy;
    logic [7:0]  w_ch_lo;
    logic [15:0] w_rd_data;

    assign w_ch_lo      = data_in[7:0];
    assign w_chan_ok    = (data_in[15:8] == 8'h00) && (w_ch_lo != 8'h00) &&
                          ((w_ch_lo & (w_ch_lo - 8'd1)) == 8'h00);
    assign w_full       = (r_fill == 2'd2);
    assign w_trl        = (r_state == S_PAYLOAD) && w_full &&
                          (data_in == TRAILER_WORD) && (r_d1 == TRAILER_WORD);
    assign w_commit     = (r_state == S_PAYLOAD) && w_full && !w_trl;
    assign w_overflow   = w_commit && (r_count == MAXC);
    assign w_drain_busy = (r_dstate != D_IDLE) || r_start;

    // Parser FSM: header hunt, channel check, delay-line commit, CRC/length verdict
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state      <= S_HUNT;
            r_d1         <= 16'h0000;
            r_d2         <= 16'h0000;
            r_fill       <= 2'd0;
            r_count      <= 4'd0;
            r_crc        <= 16'h0000;
            r_ch         <= 8'h00;
            r_wsel       <= 1'b0;
            r_rsel       <= 1'b0;
            r_start      <= 1'b0;
            r_desc_ch    <= 8'h00;
            r_desc_len   <= 4'd0;
            r_crc_valid  <= 1'b0;
            r_crc_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_crc_valid  <= 1'b0;
            r_crc_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_frame_drop <= 1'b0;
            r_start      <= 1'b0;
            case (r_state)
                S_HUNT: begin
                    if (data_in == HEADER_WORD) r_state <= S_HDR;
                    else                        r_state <= S_HUNT;
                end
                S_HDR: begin
                    if (data_in == HEADER_WORD) r_state <= S_CHAN;
                    else                        r_state <= S_HUNT;
                end
                S_CHAN: begin
                    if (data_in == HEADER_WORD) begin
                        r_state <= S_CHAN;
                    end else if (w_chan_ok) begin
                        r_ch    <= w_ch_lo;
                        r_crc   <= CRC_INIT;
                        r_count <= 4'd0;
                        r_fill  <= 2'd0;
                        r_d1    <= 16'h0000;
                        r_d2    <= 16'h0000;
                        r_state <= S_PAYLOAD;
                    end else begin
                        r_state <= S_HUNT;
                    end
                end
                S_PAYLOAD: begin
                    if (w_trl) begin
                        // d2 holds the received CRC; it is compared, never committed
                        r_state <= S_HUNT;
                        if (r_count == 4'd0) begin
                            r_len_err <= 1'b1;
                        end else if (r_crc == r_d2) begin
                            r_crc_valid <= 1'b1;
                            if (w_drain_busy) begin
                                r_frame_drop <= 1'b1;
                            end else begin
                                r_wsel     <= ~r_wsel;
                                r_rsel     <= r_wsel;
                                r_desc_ch  <= r_ch;
                                r_desc_len <= r_count;
                                r_start    <= 1'b1;
                            end
                        end else begin
                            r_crc_err <= 1'b1;
                        end
                    end else begin
                        r_d1 <= data_in;
                        r_d2 <= r_d1;
                        if (!w_full) r_fill <= r_fill + 2'd1;
                        if (w_commit) begin
                            if (w_overflow) begin
                                r_len_err <= 1'b1;
                                r_state   <= S_HUNT;
                            end else begin
                                r_crc   <= crc_fold(r_crc, r_d2);
                                r_count <= r_count + 4'd1;
                            end
                        end
                    end
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    // Capture bank write; contents are don't-care after reset
    always_ff @(posedge clk_in) begin
        if (w_commit && !w_overflow) r_bank[{r_wsel, r_count[AW-1:0]}] <= r_d2;
    end

    // Drain FSM: descriptor then payload, pointer advances only on accepted writes
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_dstate <= D_IDLE;
            r_ptr    <= '0;
        end else begin
            case (r_dstate)
                D_IDLE: begin
                    if (r_start) begin
                        r_dstate <= D_DESC;
                        r_ptr    <= '0;
                    end
                end
                D_DESC: begin
                    if (!fifo_full) r_dstate <= D_DATA;
                end
                D_DATA: begin
                    if (!fifo_full) begin
                        if (4'(r_ptr) + 4'd1 == r_desc_len) begin
                            r_dstate <= D_IDLE;
                            r_ptr    <= '0;
                        end else begin
                            r_ptr <= r_ptr + AW'(1);
                        end
                    end
                end
                default: r_dstate <= D_IDLE;
            endcase
        end
    end

    assign w_rd_data  = r_bank[{r_rsel, r_ptr}];
    assign fifo_wr_en = (r_dstate != D_IDLE) && !fifo_full;

    // FIFO data mux: descriptor in DESC, bank word in DATA
    always_comb begin
        fifo_wr_data = 16'h0000;
        case (r_dstate)
            D_DESC:  fifo_wr_data = {4'b0000, r_desc_len, r_desc_ch};
            D_DATA:  fifo_wr_data = w_rd_data;
            default: fifo_wr_data = 16'h0000;
        endcase
    end

    assign crc_valid  = r_crc_valid;
    assign crc_err    = r_crc_err;
    assign len_err    = r_len_err;
    assign frame_drop = r_frame_drop;
endmodule

// File: tb/tb_frame_parser.sv
// Bench for frame_parser: directed frames plus randomized frames scored against
// a frame-level reference model (polynomial-remainder CRC, expected FIFO word queue).
module tb_frame_parser;
    localparam logic [15:0] HDR = 16'hE0E0;
    localparam logic [15:0] TRL = 16'h0E0E;

    logic        clk_in, rst, fifo_full;
    logic [15:0] data_in;
    logic        fifo_wr_en, crc_valid, crc_err, len_err, frame_drop;
    logic [15:0] fifo_wr_data;

    int          n_cmp = 0, n_mis = 0;
    int          n_valid = 0, n_err = 0, n_len = 0, n_drop = 0;
    logic        rand_full = 1'b0;
    logic [15:0] pl [0:15];
    logic [15:0] exp_q [$];

    frame_parser dut (
        .clk_in(clk_in), .rst(rst), .data_in(data_in), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .crc_valid(crc_valid),
        .crc_err(crc_err), .len_err(len_err), .frame_drop(frame_drop)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of (crc ^ word) * x^16 divided by x^16 + 0x1021
    function automatic logic [15:0] model_crc(input int n);
        logic [31:0] v;
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < n; i++) begin
            v = {r ^ pl[i], 16'h0000};
            for (int b = 31; b >= 16; b--)
                if (v[b]) v = v ^ (32'h0001_1021 << (b - 16));
            r = v[15:0];
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        while (w == HDR || w == TRL) w = 16'($urandom);
        return w;
    endfunction

    // Output monitor: pulse counters, pulse exclusivity, FIFO scoreboard
    always @(negedge clk_in) begin
        if (!rst) begin
            if (crc_valid)  n_valid++;
            if (crc_err)    n_err++;
            if (len_err)    n_len++;
            if (frame_drop) n_drop++;
            if (crc_valid || crc_err || len_err)
                chk("pulse_excl", $countones({crc_valid, crc_err, len_err}), 1);
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) chk("fifo_unexpected_wr", {16'h0, fifo_wr_data}, 32'hFFFF_FFFF);
                else                   chk("fifo_data", fifo_wr_data, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [15:0] w);
        @(posedge clk_in);
        #1;
        data_in = w;
        if (rand_full) fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            drive(16'h0000);
            k++;
        end
        chk("drain_done", exp_q.size(), 0);
        drive(16'h0000);
        drive(16'h0000);
    endtask

    task automatic run_frame(input logic [15:0] ch, input int n, input logic [15:0] crc_xor,
                             input logic exp_drop);
        logic [15:0] crc;
        logic        ok, ev, ee, el;
        int          v0, e0, l0, d0;
        crc = model_crc(n);
        ok  = (ch[15:8] == 8'h00) && ($countones(ch[7:0]) == 1);
        ev  = ok && n >= 1 && n <= 8 && crc_xor == 16'h0000;
        ee  = ok && n >= 1 && n <= 8 && crc_xor != 16'h0000;
        el  = ok && (n == 0 || n > 8);
        if (ev && !exp_drop) begin
            exp_q.push_back({4'h0, 4'(n), ch[7:0]});
            for (int i = 0; i < n; i++) exp_q.push_back(pl[i]);
        end
        v0 = n_valid; e0 = n_err; l0 = n_len; d0 = n_drop;
        repeat (2 + $urandom_range(0, 1)) drive(HDR);
        drive(ch);
        for (int i = 0; i < n; i++) drive(pl[i]);
        drive(crc ^ crc_xor);
        drive(TRL);
        drive(TRL);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("crc_valid", crc_valid, ev);
        chk("crc_err", crc_err, ee);
        chk("frame_drop", frame_drop, ev && exp_drop);
        chk("len_err_at_trailer", len_err, ok && n == 0);
        @(negedge clk_in);
        chk("valid_count", n_valid - v0, ev);
        chk("err_count", n_err - e0, ee);
        chk("len_count", n_len - l0, el);
        chk("drop_count", n_drop - d0, ev && exp_drop);
    endtask

    initial begin
        rst = 1'b1; data_in = 16'h0000; fifo_full = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 0);
        chk("rst_pulses", {crc_valid, crc_err, len_err, frame_drop}, 0);
        @(posedge clk_in); #1; rst = 1'b0;

        // Minimal one-word frame, good and bad CRC
        pl[0] = 16'h0001;
        chk("model_crc_1", model_crc(1), 16'h1021);
        run_frame(16'h0001, 1, 16'h0000, 1'b0);
        wait_drain();
        run_frame(16'h0001, 1, 16'hEFDE, 1'b0);
        wait_drain();

        // Eight-word frames, free running then with a 5-cycle stall mid-drain
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 8; i++) pl[i] = (t == 2) ? 16'(i + 1) : 16'h0000;
            run_frame(16'h0002, 8, 16'h0000, 1'b0);
            if (t > 0) begin
                drive(16'h0000);
                fifo_full = 1'b1;
                repeat (5) begin
                    @(negedge clk_in);
                    chk("stall_wr_en", fifo_wr_en, 0);
                    chk("stall_hold", fifo_wr_data, exp_q[0]);
                end
                @(posedge clk_in); #1; fifo_full = 1'b0;
            end
            wait_drain();
        end

        // Length errors: nine words, zero words
        for (int i = 0; i < 9; i++) pl[i] = rand_word();
        run_frame(16'h0004, 9, 16'h0000, 1'b0);
        wait_drain();
        run_frame(16'h0004, 0, 16'h1021, 1'b0);
        wait_drain();

        // Rejected channel words, then a valid frame
        pl[0] = 16'h1234; pl[1] = 16'h5678;
        run_frame(16'h0003, 2, 16'h0000, 1'b0);
        run_frame(16'h0101, 2, 16'h0000, 1'b0);
        run_frame(16'h0020, 2, 16'h0000, 1'b0);
        wait_drain();

        // Back-to-back good frames with FIFO held full: second one is dropped
        fifo_full = 1'b1;
        for (int i = 0; i < 8; i++) pl[i] = rand_word();
        run_frame(16'h0080, 8, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) pl[i] = rand_word();
        run_frame(16'h0001, 8, 16'h0000, 1'b1);
        @(posedge clk_in); #1; fifo_full = 1'b0;
        wait_drain();

        // Reset mid-payload while a stalled drain is pending
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) pl[i] = rand_word();
        run_frame(16'h0040, 4, 16'h0000, 1'b0);
        drive(HDR); drive(HDR); drive(16'h0004); drive(rand_word()); drive(rand_word());
        @(posedge clk_in); #1; rst = 1'b1; fifo_full = 1'b0;
        @(negedge clk_in);
        chk("midrst_wr_en", fifo_wr_en, 0);
        chk("midrst_wr_data", fifo_wr_data, 0);
        chk("midrst_pulses", {crc_valid, crc_err, len_err, frame_drop}, 0);
        exp_q.delete();
        @(posedge clk_in); #1; rst = 1'b0;
        for (int i = 0; i < 3; i++) pl[i] = rand_word();
        run_frame(16'h0008, 3, 16'h0000, 1'b0);
        wait_drain();

        // Randomized frames with random FIFO back-pressure
        rand_full = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int          r, n;
            logic [15:0] ch, cx;
            r  = $urandom_range(0, 9);
            ch = (r == 0) ? 16'h0003 + 16'($urandom_range(0, 1)) * 16'h0100 : 16'(1 << $urandom_range(0, 7));
            n  = (r == 1) ? 0 : (r == 2) ? 9 + $urandom_range(0, 1) : $urandom_range(1, 8);
            cx = (r == 3) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            do begin
                for (int i = 0; i < n; i++) pl[i] = rand_word();
            end while ((model_crc(n) ^ cx) == TRL);
            repeat ($urandom_range(0, 3)) drive(rand_word());
            run_frame(ch, n, cx, 1'b0);
            wait_drain();
        end
        rand_full = 1'b0;
        fifo_full = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
